mul_add_seq: RTL and testbench

- Sequential unsigned multiply-add: p = a*b + c, computed by shift-add, one partial product per clock.
- Inverse of the sequential divider. Feeding the divider's quotient, divisor and remainder as a, b and c reconstructs the dividend.
- Used as the divider's round-trip checker and as a general multiplier in the stage-1 arithmetic set.
- Same start/done handshake style as the divider; fixed latency.

---
 rtl/mul_add_seq.sv | 100 ++++++++++
 tb/tb_mul_add_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// ============================================================================
// mul_add_seq : sequential unsigned multiply-add, p = a*b + c (shift-add)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand, mcand_nxt;
  logic [WIDTH-1:0] mplr, mplr_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             busy_nxt, done_nxt;
  logic [PW-1:0]    p_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      mplr  <= mplr_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      p     <= p_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    mplr_nxt  = mplr;
    acc_nxt   = acc;
    count_nxt = count;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    p_nxt     = p;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt = {{WIDTH{1'b0}}, a};
          mplr_nxt  = b;
          acc_nxt   = {{WIDTH{1'b0}}, c};
          count_nxt = CW'(WIDTH);
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count != '0) begin
          // Max result is 2^2W - 2^W, so the 2W-bit accumulator never carries out.
          acc_nxt   = acc + (mplr[0] ? mcand : '0);
          mcand_nxt = mcand << 1;
          mplr_nxt  = mplr >> 1;
          count_nxt = count - CW'(1);
        end else begin
          p_nxt     = acc;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_add_seq.sv
// ============================================================================
// tb_mul_add_seq : directed self-checking bench for mul_add_seq (WIDTH=16)
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_add_seq;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a, b, c;
  logic           busy, done;
  logic [2*W-1:0] p;

  int n_checks;
  int n_fails;

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, output logic busy_e0,
                        output int lat, output logic [2*W-1:0] res);
    a = ia; b = ib; c = ic;
    start = 1'b1;
    step();
    busy_e0 = busy;
    start = 1'b0;
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin
        lat = k;
        res = p;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      n_fails++;
      $display("FAIL reset_state: busy=%b done=%b p=%h, required 0 0 00000000", busy, done, p);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic be; int lat; logic [2*W-1:0] res;
    run_op(16'd300, 16'd7, 16'd5, be, lat, res);
    n_checks++;
    if (be !== 1'b1) begin
      n_fails++; $display("FAIL basic_busy_rise: busy=%b, required 1", be);
    end
    n_checks++;
    if (lat !== 17) begin
      n_fails++; $display("FAIL basic_latency: edges=%0d, required 17", lat);
    end
    n_checks++;
    if (res !== 32'h0000_0839) begin
      n_fails++; $display("FAIL basic_p: p=%h, required 00000839", res);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || p !== 32'h0000_0839) begin
      n_fails++; $display("FAIL basic_done_width: done=%b p=%h, required 0 00000839", done, p);
    end
  endtask

  task automatic test_round_trip();
    logic be; int lat; logic [2*W-1:0] res;
    logic [W-1:0] x, d, q, r;
    run_op(16'd406, 16'd123, 16'd62, be, lat, res);
    n_checks++;
    if (res !== 32'd50000 || lat !== 17) begin
      n_fails++; $display("FAIL round_trip_fixed: p=%h lat=%0d, required 0000c350 17", res, lat);
    end
    for (int i = 0; i < 200; i++) begin
      x = W'($urandom);
      d = W'($urandom_range(1, 65535));
      q = x / d;
      r = x % d;
      run_op(q, d, r, be, lat, res);
      n_checks++;
      if (res !== {16'h0, x}) begin
        n_fails++;
        $display("FAIL round_trip_%0d: q=%h d=%h r=%h p=%h, required %h", i, q, d, r, res, {16'h0, x});
      end
    end
  endtask

  task automatic test_extremes();
    logic be; int lat; logic [2*W-1:0] res;
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, be, lat, res);
    n_checks++;
    if (res !== 32'hFFFF_0000) begin
      n_fails++; $display("FAIL extreme_max: p=%h, required ffff0000", res);
    end
    run_op(16'h0000, 16'hABCD, 16'h1234, be, lat, res);
    n_checks++;
    if (res !== 32'h0000_1234 || lat !== 17) begin
      n_fails++; $display("FAIL extreme_a_zero: p=%h lat=%0d, required 00001234 17", res, lat);
    end
    run_op(16'h0001, 16'h8000, 16'h0000, be, lat, res);
    n_checks++;
    if (res !== 32'h0000_8000) begin
      n_fails++; $display("FAIL extreme_msb: p=%h, required 00008000", res);
    end
  endtask

  task automatic test_interference();
    int pulses; logic [2*W-1:0] res;
    a = 16'd10; b = 16'd10; c = 16'd0;
    start = 1'b1;
    step();                                // E0
    start = 1'b0;
    pulses = 0; res = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h1234; c = 16'h5678;
      end
      if (k == 10) start = 1'b0;
      step();
      if (done) begin
        pulses++;
        res = p;
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fails++; $display("FAIL interference_pulses: pulses=%0d, required 1", pulses);
    end
    n_checks++;
    if (res !== 32'd100) begin
      n_fails++; $display("FAIL interference_p: p=%h, required 00000064", res);
    end
  endtask

  task automatic test_reset_mid_op();
    logic be; int lat; logic [2*W-1:0] res; int pulses;
    a = 16'd50; b = 16'd60; c = 16'd7;
    start = 1'b1;
    step();                                // E0
    start = 1'b0;
    repeat (8) step();                     // E1..E8
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || p !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_op: done=%b busy=%b p=%h, required 0 0 00000000", done, busy, p);
    end
    step();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done || busy) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fails++; $display("FAIL reset_no_done: active_cycles=%0d, required 0", pulses);
    end
    run_op(16'd3, 16'd4, 16'd1, be, lat, res);
    n_checks++;
    if (res !== 32'd13 || lat !== 17) begin
      n_fails++; $display("FAIL reset_recover: p=%h lat=%0d, required 0000000d 17", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, bad_p, bad_gap, bad_busy, last;
    a = 16'd2; b = 16'd3; c = 16'd1;
    start = 1'b1;
    pulses = 0; bad_p = 0; bad_gap = 0; bad_busy = 0; last = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (busy !== ~done) bad_busy++;
      if (done) begin
        pulses++;
        if (p !== 32'd7) bad_p++;
        if (k - last != 18) bad_gap++;
        last = k;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 25 && (busy || done); k++) step();
    n_checks++;
    if (pulses !== 3) begin
      n_fails++; $display("FAIL b2b_pulses: pulses=%0d, required 3", pulses);
    end
    n_checks++;
    if (bad_p !== 0 || bad_gap !== 0) begin
      n_fails++; $display("FAIL b2b_p_period: bad_p=%0d bad_gap=%0d, required 0 0", bad_p, bad_gap);
    end
    n_checks++;
    if (bad_busy !== 0) begin
      n_fails++; $display("FAIL b2b_busy: cycles_busy_eq_done=%0d, required 0", bad_busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_basic();
    test_round_trip();
    test_extremes();
    test_interference();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
